if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the program counter and generates pc_plus and the instruction-memory address. It takes the redirect targets (pc_br, pc_j, pc_jr) and their take signals from the ID stage, and drives the IF/ID pipeline register that feeds decode and the branch/jump target unit. Hazard control arrives as stall and redirect inputs.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_id_reg.sv | 45 ++++
 rtl/if_stage.sv | 97 +++++++++
 tb/tb_if_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/bubble constants and the next-PC select encoding.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_BR,
      SEL_J,
      SEL_JR
   } pc_sel_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush; reset and flush both insert a bubble.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] instru,
   input  logic [31:0] pc_plus,
   output logic [31:0] id_instru,
   output logic [31:0] id_pc_plus,
   output logic        id_valid
);

   logic [31:0] instru_reg;
   logic [31:0] pc_plus_reg;
   logic        valid_reg;

   // Hold outranks flush so a stalled stage never loses its contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         instru_reg  <= NOP_INSTR;
         pc_plus_reg <= 32'd0;
         valid_reg   <= 1'b0;
      end else if (hold) begin
         instru_reg  <= instru_reg;
         pc_plus_reg <= pc_plus_reg;
         valid_reg   <= valid_reg;
      end else if (flush) begin
         instru_reg  <= NOP_INSTR;
         pc_plus_reg <= 32'd0;
         valid_reg   <= 1'b0;
      end else begin
         instru_reg  <= instru;
         pc_plus_reg <= pc_plus;
         valid_reg   <= 1'b1;
      end
   end

   assign id_instru  = instru_reg;
   assign id_pc_plus = pc_plus_reg;
   assign id_valid   = valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic        j_taken,
   input  logic        jr_taken,
   input  logic [31:0] pc_br,
   input  logic [31:0] pc_j,
   input  logic [31:0] pc_jr,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] pc,
   output logic [31:0] pc_plus,
   output logic [31:0] id_instru,
   output logic [31:0] id_pc_plus,
   output logic        id_valid,
   output logic        fetch_err
);

   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic        fetch_err_reg;
   logic        fetch_err_next;
   logic [31:0] target;
   logic        redirect;
   pc_sel_e     pc_sel;

   assign redirect  = br_taken | j_taken | jr_taken;
   assign pc        = pc_reg;
   assign pc_plus   = pc_reg + 32'd4;
   assign imem_addr = pc_reg;
   assign fetch_err = fetch_err_reg;

   // Redirects are ignored while stalled: ID's decision is not final until the stall clears.
   always_comb begin
      pc_sel = SEL_SEQ;
      target = pc_br;
      if (stall) begin
         pc_sel = SEL_HOLD;
      end else if (jr_taken) begin
         pc_sel = SEL_JR;
         target = pc_jr;
      end else if (j_taken) begin
         pc_sel = SEL_J;
         target = pc_j;
      end else if (br_taken) begin
         pc_sel = SEL_BR;
         target = pc_br;
      end
   end

   always_comb begin
      pc_next        = pc_plus;
      fetch_err_next = fetch_err_reg;
      case (pc_sel)
         SEL_HOLD: pc_next = pc_reg;
         SEL_SEQ:  pc_next = pc_plus;
         SEL_BR, SEL_J, SEL_JR: begin
            pc_next        = word_align(target);
            fetch_err_next = fetch_err_reg | (target[1:0] != 2'b00);
         end
         default:  pc_next = pc_plus;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg        <= RESET_PC;
         fetch_err_reg <= 1'b0;
      end else begin
         pc_reg        <= pc_next;
         fetch_err_reg <= fetch_err_next;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .hold       (stall),
      .flush      (redirect),
      .instru     (imem_data),
      .pc_plus    (pc_plus),
      .id_instru  (id_instru),
      .id_pc_plus (id_pc_plus),
      .id_valid   (id_valid)
   );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, then random stimulus against a reference model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic        j_taken = 1'b0;
   logic        jr_taken = 1'b0;
   logic [31:0] pc_br = '0;
   logic [31:0] pc_j = '0;
   logic [31:0] pc_jr = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data = '0;
   logic [31:0] pc;
   logic [31:0] pc_plus;
   logic [31:0] id_instru;
   logic [31:0] id_pc_plus;
   logic        id_valid;
   logic        fetch_err;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state
   logic [31:0] m_pc = 32'h0000_3000;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pcp = '0;
   logic        m_valid = 1'b0;
   logic        m_err = 1'b0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_taken   (br_taken),
      .j_taken    (j_taken),
      .jr_taken   (jr_taken),
      .pc_br      (pc_br),
      .pc_j       (pc_j),
      .pc_jr      (pc_jr),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .pc         (pc),
      .pc_plus    (pc_plus),
      .id_instru  (id_instru),
      .id_pc_plus (id_pc_plus),
      .id_valid   (id_valid),
      .fetch_err  (fetch_err)
   );

   typedef struct {
      logic        rst, stall, br, j, jr;
      logic [31:0] pc_br, pc_j, pc_jr, imem;
      logic [31:0] e_pc, e_instr, e_pcp;
      logic        e_valid, e_err;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Behavioural model written straight from the fetch rules.
   task automatic model_step();
      logic [31:0] t;
      if (rst) begin
         m_pc = 32'h0000_3000; m_instr = '0; m_pcp = '0; m_valid = 1'b0; m_err = 1'b0;
      end else if (stall) begin
         // everything holds
      end else if (br_taken || j_taken || jr_taken) begin
         t = jr_taken ? pc_jr : (j_taken ? pc_j : pc_br);
         if (t % 4 != 0) m_err = 1'b1;
         m_pc = t - (t % 4);
         m_instr = '0; m_pcp = '0; m_valid = 1'b0;
      end else begin
         m_instr = imem_data; m_pcp = m_pc + 4; m_valid = 1'b1;
         m_pc = m_pc + 4;
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic b, input logic j, input logic jr,
                        input logic [31:0] tb_, input logic [31:0] tj, input logic [31:0] tjr,
                        input logic [31:0] im);
      rst = r; stall = s; br_taken = b; j_taken = j; jr_taken = jr;
      pc_br = tb_; pc_j = tj; pc_jr = tjr; imem_data = im;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input int idx, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pcp, input logic e_valid, input logic e_err);
      check("pc", idx, pc, e_pc);
      check("pc_plus", idx, pc_plus, e_pc + 32'd4);
      check("imem_addr", idx, imem_addr, e_pc);
      check("id_instru", idx, id_instru, e_instr);
      check("id_pc_plus", idx, id_pc_plus, e_pcp);
      check("id_valid", idx, {31'd0, id_valid}, {31'd0, e_valid});
      check("fetch_err", idx, {31'd0, fetch_err}, {31'd0, e_err});
   endtask

   localparam logic [31:0] I0 = 32'h2001_0005;

   initial begin
      //          rst stall br j jr  pc_br         pc_j          pc_jr         imem           e_pc          e_instr       e_pcp         v  err
      vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        I0,            32'h3000,     32'h0,        32'h0,        0, 0};
      vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        I0,            32'h3004,     I0,           32'h3004,     1, 0};
      vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        I0,            32'h3008,     I0,           32'h3008,     1, 0};
      vecs[3]  = '{0, 0, 1, 0, 0, 32'h3040,     32'h0,        32'h0,        I0,            32'h3040,     32'h0,        32'h0,        0, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        I0,            32'h3044,     I0,           32'h3044,     1, 0};
      vecs[5]  = '{0, 0, 0, 1, 0, 32'h0,        32'h300C,     32'h0,        I0,            32'h300C,     32'h0,        32'h0,        0, 0};
      vecs[6]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        I0,            32'h3010,     I0,           32'h3010,     1, 0};
      vecs[7]  = '{0, 1, 1, 0, 0, 32'h3400,     32'h0,        32'h0,        32'hDEADBEEF,  32'h3010,     I0,           32'h3010,     1, 0};
      vecs[8]  = '{0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF,  32'h3010,     I0,           32'h3010,     1, 0};
      vecs[9]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h11112222,  32'h3014,     32'h11112222, 32'h3014,     1, 0};
      vecs[10] = '{0, 1, 0, 1, 0, 32'h0,        32'h3100,     32'h0,        I0,            32'h3014,     32'h11112222, 32'h3014,     1, 0};
      vecs[11] = '{0, 0, 0, 1, 0, 32'h0,        32'h3100,     32'h0,        I0,            32'h3100,     32'h0,        32'h0,        0, 0};
      vecs[12] = '{0, 0, 1, 0, 1, 32'h3300,     32'h0,        32'h3202,     I0,            32'h3200,     32'h0,        32'h0,        0, 1};
      vecs[13] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        I0,            32'h3204,     I0,           32'h3204,     1, 1};
      vecs[14] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        I0,            32'h3208,     I0,           32'h3208,     1, 1};
      vecs[15] = '{1, 0, 1, 0, 0, 32'h3040,     32'h0,        32'h0,        I0,            32'h3000,     32'h0,        32'h0,        0, 0};
      vecs[16] = '{0, 0, 0, 1, 0, 32'h0,        32'hFFFFFFFC, 32'h0,        I0,            32'hFFFFFFFC, 32'h0,        32'h0,        0, 0};
      vecs[17] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000ABCD,  32'h0,        32'h0000ABCD, 32'h0,        1, 0};
      vecs[18] = '{0, 0, 0, 1, 0, 32'h0,        32'h3101,     32'h0,        I0,            32'h3100,     32'h0,        32'h0,        0, 1};
      vecs[19] = '{1, 1, 0, 1, 1, 32'h0,        32'h3100,     32'h3200,     I0,            32'h3000,     32'h0,        32'h0,        0, 0};

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].j, vecs[i].jr,
               vecs[i].pc_br, vecs[i].pc_j, vecs[i].pc_jr, vecs[i].imem);
         tick();
         check_all(i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcp, vecs[i].e_valid, vecs[i].e_err);
      end

      // Hand sequence: misaligned br target, fetch_err survives a long stall and normal cycles.
      drive(0, 0, 1, 0, 0, 32'h0000_5003, 0, 0, I0); tick();
      check_all(100, 32'h5000, 32'h0, 32'h0, 0, 1);
      drive(0, 1, 0, 0, 0, 0, 0, 0, I0); repeat (3) tick();
      check_all(101, 32'h5000, 32'h0, 32'h0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678); tick();
      check_all(102, 32'h5004, 32'h1234_5678, 32'h5004, 1, 1);

      // Random phase, compared against the reference model.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      for (int k = 0; k < 400; k++) begin
         logic [31:0] rb, rj, rjr;
         rb  = $urandom; rj = $urandom; rjr = $urandom;
         if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) rj[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) rjr[1:0] = 2'b00;
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0,
               rb, rj, rjr, $urandom);
         tick();
         check_all(1000 + k, m_pc, m_instr, m_pcp, m_valid, m_err);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
